router_link_tx: RTL and testbench

//  Output-side link transmitter for a router port: drains the port's input buffer FIFO
//  (rd_en/empty handshake, data registered one cycle after rd_en) and drives flits onto
//  the inter-router link under credit-based flow control. Sits between the buffer FIFO

---
 rtl/router_link_tx.sv | 109 ++++++++++
 tb/tb_router_link_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_link_tx.sv
// Router output link transmitter: drains the port buffer FIFO onto the link under credit flow control.
// Optional build macro LINK_PARITY_EN adds a registered even-parity bit (link_parity) alongside link_data.
module router_link_tx #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned CREDITS  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             tx_en,
    input  logic                             fifo_empty,
    input  logic [NUM_BITS-1:0]              fifo_data,
    output logic                             fifo_rd_en,
    input  logic                             credit_in,
    output logic [NUM_BITS-1:0]              link_data,
    output logic                             link_valid,
    output logic [clog2(CREDITS+1)-1:0]      credit_cnt,
    output logic                             credit_err,
    output logic                             tx_idle
`ifdef LINK_PARITY_EN
    ,
    output logic                             link_parity
`endif
);

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) res = i + 1;
        end
        return res;
    endfunction

    localparam int unsigned CW = clog2(CREDITS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   rd_pend;
    logic   cnt_full_c;
    logic   credit_ovf_c;

    assign fifo_rd_en   = (state_q == ACTIVE) & tx_en & ~fifo_empty & (credit_cnt != '0);
    assign cnt_full_c   = (credit_cnt == CW'(CREDITS));
    assign credit_ovf_c = credit_in & ~fifo_rd_en & cnt_full_c;
    assign tx_idle      = (state_q == IDLE) & ~rd_pend & ~link_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; DRAIN waits for the read pipeline to empty
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (tx_en) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!tx_en) state_d = (rd_pend || link_valid) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (tx_en)                        state_d = ACTIVE;
                else if (!rd_pend && !link_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-to-link pipeline: FIFO data is valid the cycle after rd_en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend    <= 1'b0;
            link_valid <= 1'b0;
            link_data  <= '0;
        end else begin
            rd_pend    <= fifo_rd_en;
            link_valid <= rd_pend;
            if (rd_pend) link_data <= fifo_data;
        end
    end

`ifdef LINK_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       link_parity <= 1'b0;
        else if (rd_pend) link_parity <= ^fifo_data;
    end
`endif

    // Credits are reserved on the read; a return at full count is held and flagged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt <= CW'(CREDITS);
            credit_err <= 1'b0;
        end else begin
            if (fifo_rd_en && !credit_in)                    credit_cnt <= credit_cnt - CW'(1);
            else if (!fifo_rd_en && credit_in && !cnt_full_c) credit_cnt <= credit_cnt + CW'(1);
            if (credit_ovf_c) credit_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_router_link_tx.sv
// Scoreboard bench for router_link_tx: a FIFO model feeds the DUT, a link monitor checks flit order and latency.
// Build with LINK_PARITY_EN defined to also check link_parity.
module tb_router_link_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       credit_in;
    logic [7:0] link_data;
    logic       link_valid;
    logic [3:0] credit_cnt;
    logic       credit_err;
    logic       tx_idle;
`ifdef LINK_PARITY_EN
    logic       link_parity;
`endif

    always #5 clk = ~clk;

    router_link_tx #(.NUM_BITS(8), .CREDITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .credit_in  (credit_in),
        .link_data  (link_data),
        .link_valid (link_valid),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err),
        .tx_idle    (tx_idle)
`ifdef LINK_PARITY_EN
        ,
        .link_parity(link_parity)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] mem [0:63];
    int         wr_cnt   = 0;
    int         rd_cnt   = 0;
    int         cyc      = 0;
    int         rd_total = 0;
    int         sent     = 0;
    logic [7:0] exp_q [$];
    int         lat_q [$];

    assign fifo_empty = (wr_cnt == rd_cnt);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // FIFO model: data registered one cycle after rd_en; reset flushes it
    always @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt <= wr_cnt;
            lat_q.delete();
        end else if (fifo_rd_en) begin
            check("rd_on_empty", int'(fifo_empty), 0);
            fifo_data <= mem[rd_cnt % 64];
            rd_cnt    <= rd_cnt + 1;
            rd_total  <= rd_total + 1;
            lat_q.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    // Link monitor: pops the scoreboard on every valid flit
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst_n) begin
            exp_q.delete();
        end else if (link_valid) begin
            sent++;
            if (exp_q.size() == 0) fail("unexpected_flit");
            else begin
                e = exp_q.pop_front();
                check("link_data", int'(link_data), int'(e));
`ifdef LINK_PARITY_EN
                check("link_parity", int'(link_parity), int'(^e));
`endif
            end
            if (lat_q.size() == 0) fail("flit_without_read");
            else check("rd_to_link_latency", cyc - lat_q.pop_front(), 2);
        end
    end

    task automatic push(input logic [7:0] d, input bit expect_it);
        mem[wr_cnt % 64] = d;
        wr_cnt++;
        if (expect_it) exp_q.push_back(d);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic credit_pulse();
        credit_in = 1'b1;
        @(negedge clk);
        credit_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int base_s;
        int base_r;
        bit idle_seen;

        rst_n = 1'b1; tx_en = 1'b0; credit_in = 1'b0; fifo_data = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("reset_link_valid", int'(link_valid), 0);
        check("reset_credit_cnt", int'(credit_cnt), 8);
        check("reset_credit_err", int'(credit_err), 0);
        check("reset_tx_idle",    int'(tx_idle), 1);
        check("reset_rd_en",      int'(fifo_rd_en), 0);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);

        // Stream of three flits
        base_r = rd_total; base_s = sent;
        push(8'h11, 1); push(8'h22, 1); push(8'h33, 1);
        tx_en = 1'b1;
        cycles(1);
        check("stream_first_rd_en", int'(fifo_rd_en), 1);
        cycles(3);
        check("stream_reads_back_to_back", rd_total - base_r, 3);
        check("stream_rd_en_after_empty", int'(fifo_rd_en), 0);
        cycles(4);
        check("stream_flits_sent", sent - base_s, 3);
        check("stream_credit_cnt", int'(credit_cnt), 5);
        repeat (3) credit_pulse();
        check("credits_returned", int'(credit_cnt), 8);

        // Credit stall with ten flits queued
        base_s = sent;
        for (int i = 0; i < 10; i++) push(8'(8'hA0 + i), 1);
        cycles(14);
        check("stall_flits_sent", sent - base_s, 8);
        check("stall_credit_cnt", int'(credit_cnt), 0);
        check("stall_rd_en", int'(fifo_rd_en), 0);
        credit_pulse();
        cycles(4);
        check("one_credit_one_flit", sent - base_s, 9);
        check("one_credit_cnt", int'(credit_cnt), 0);
        cycles(5);
        check("one_credit_no_extra", sent - base_s, 9);
        credit_pulse();
        cycles(4);
        check("stall_all_sent", sent - base_s, 10);
        repeat (8) credit_pulse();
        check("stall_credits_restored", int'(credit_cnt), 8);

        // Read and credit return in the same cycle
        push(8'h41, 1); push(8'h42, 1); push(8'h43, 1); push(8'h44, 1);
        cycles(8);
        check("simul_pre_cnt", int'(credit_cnt), 4);
        push(8'h5A, 1);
        credit_in = 1'b1;
        #1;
        check("simul_rd_en", int'(fifo_rd_en), 1);
        @(negedge clk);
        credit_in = 1'b0;
        check("simul_cnt_unchanged", int'(credit_cnt), 4);
        cycles(4);
        repeat (4) credit_pulse();
        check("simul_cnt_full", int'(credit_cnt), 8);
        check("no_err_before_overflow", int'(credit_err), 0);
        credit_pulse();
        check("overflow_cnt_held", int'(credit_cnt), 8);
        check("overflow_err_set", int'(credit_err), 1);
        cycles(5);
        check("overflow_err_sticky", int'(credit_err), 1);

        // Drain: tx_en drops the cycle after a read
        base_s = sent; base_r = rd_total;
        push(8'h6B, 1);
        #1;
        check("drain_read_issued", int'(fifo_rd_en), 1);
        @(negedge clk);
        tx_en = 1'b0;
        push(8'h7C, 0);
        idle_seen = 1'b0;
        for (int i = 0; i < 6 && !idle_seen; i++) begin
            @(negedge clk);
            if (tx_idle) idle_seen = 1'b1;
            else if (fifo_rd_en) fail("drain_read_while_stopped");
        end
        check("drain_reaches_idle", int'(idle_seen), 1);
        check("drain_flit_delivered", sent - base_s, 1);
        check("drain_single_read", rd_total - base_r, 1);
        exp_q.push_back(8'h7C);
        tx_en = 1'b1;
        cycles(6);
        check("resume_flit_delivered", sent - base_s, 2);

        // Parity pattern (link_parity checked by the monitor when enabled)
        base_s = sent;
        push(8'h07, 1); push(8'h03, 1);
        cycles(6);
        check("parity_flits_sent", sent - base_s, 2);
        check("parity_credit_cnt", int'(credit_cnt), 4);

        // Asynchronous reset mid-transfer
        push(8'hC1, 1); push(8'hC2, 1); push(8'hC3, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_link_valid", int'(link_valid), 0);
        check("midreset_credit_cnt", int'(credit_cnt), 8);
        check("midreset_credit_err", int'(credit_err), 0);
        check("midreset_tx_idle", int'(tx_idle), 1);
        check("midreset_rd_en", int'(fifo_rd_en), 0);
        cycles(2);
        tx_en = 1'b0;
        rst_n = 1'b1;
        cycles(3);
        base_s = sent;
        push(8'h99, 1);
        tx_en = 1'b1;
        cycles(6);
        check("post_reset_flit", sent - base_s, 1);
        check("post_reset_credit_cnt", int'(credit_cnt), 7);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
